mem_wait_responder: RTL and testbench
=====================================

MEM_WAIT_RESPONDER -- requirements
Module: mem_wait_responder

Interface
REQ-001 Parameter ADDR_BITS, default 6: word-address width; internal RAM holds 2^ADDR_BITS 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and response; legal range 0..15.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a memory request.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address; word index = req_addr[ADDR_BITS+1:2].
REQ-008 req_wdata  input  32  write data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator accepts the response.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  request was misaligned or out of range.
REQ-014 acc_count  output  16  count of completed responses.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready on a rising edge.
REQ-017 On acceptance, req_we, req_addr and req_wdata SHALL be captured; later input changes have no effect on the transaction.
REQ-018 IDLE -> WAIT on acceptance when WAIT_CYCLES > 0; IDLE -> RESP directly when WAIT_CYCLES = 0.
REQ-019 WAIT: a 4-bit down-counter loads WAIT_CYCLES-1 on acceptance and decrements each cycle; WAIT -> RESP when the counter is 0.
REQ-020 Latency: rsp_valid first asserts exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-021 Error: captured addr[1:0] != 0, or any addr bit above ADDR_BITS+1 is 1 -> rsp_err = 1 and rsp_rdata = 0. Errored writes SHALL NOT modify RAM.
REQ-022 Non-errored write SHALL update RAM on the edge that enters RESP.
REQ-023 Non-errored read SHALL latch RAM[index] into rsp_rdata on the edge that enters RESP.
REQ-024 rsp_rdata and rsp_err SHALL hold stable while rsp_valid = 1.
REQ-025 RESP: rsp_valid = 1; stay while rsp_ready = 0; on rsp_valid & rsp_ready -> IDLE and acc_count increments.
REQ-026 A new request SHALL NOT be accepted in the cycle the response completes; req_ready rises in the following cycle (IDLE).
REQ-027 acc_count SHALL wrap from 16'hFFFF to 0.
REQ-028 acc_count SHALL count errored responses.
REQ-029 Read-after-write to the same address SHALL return the newly written data.

Reset
REQ-030 While reset = 1: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, acc_count = 0, wait counter = 0.
REQ-031 Reset in WAIT SHALL abort the transaction: a pending write is discarded and no response is produced.
REQ-032 Reset in RESP SHALL drop the response: the RAM write already committed is kept, and acc_count is not incremented beyond its reset value.
REQ-033 RAM contents SHALL NOT be initialised by reset.

Verification
REQ-034 WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 with rsp_ready=1 -> rsp_valid 3 cycles after acceptance, rsp_err=0, acc_count=1; then read 0x10 -> rsp_rdata=0xDEADBEEF, acc_count=2.
REQ-035 Read 0x12 (misaligned) and read 0x100 (out of range, ADDR_BITS=6) -> rsp_err=1 and rsp_rdata=0 for each; a prior write to 0x100 leaves RAM word 0 unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready=0; when rsp_ready=1 -> IDLE next cycle, and a request held on req_valid is accepted one cycle later.
REQ-037 Assert reset during WAIT of a write to 0x20 (old value 0x1111) -> no rsp_valid, all outputs at reset values; a subsequent read of 0x20 returns 0x1111.
REQ-038 WAIT_CYCLES=0 -> rsp_valid asserts 1 cycle after acceptance; back-to-back requests with rsp_ready=1 complete one every 2 cycles.
REQ-039 Force acc_count to 0xFFFF via 65535 completed transactions (or by preloading it in the bench), then complete one more -> acc_count = 0.

Source files
------------

// File: rtl/mem_wait_responder.sv
// mem_wait_responder
//   Single-outstanding memory responder with a fixed number of wait states.
//   A request is accepted in IDLE, held for WAIT_CYCLES cycles in WAIT, and
//   answered from an internal 2^ADDR_BITS x 32-bit RAM in RESP. The response
//   stays up until the initiator takes it.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  initiator presents a request
//   req_we     1 = write, 0 = read
//   req_addr   byte address; word index = req_addr[ADDR_BITS+1:2]
//   req_wdata  write data
//   req_ready  responder can accept a request (IDLE only)
//   rsp_valid  response available (RESP only)
//   rsp_ready  initiator accepts the response
//   rsp_rdata  read data; 0 for writes and errored requests
//   rsp_err    request was misaligned or out of range
//   acc_count  number of completed responses, wraps at 16 bits
module mem_wait_responder #(
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] acc_count
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Counter preload so that exactly WAIT_CYCLES cycles are spent in WAIT.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] acc_count_q, acc_count_d;

  logic [31:0] mem [DEPTH];

  logic                 enter_resp;
  logic                 mem_we;
  logic                 cur_we;
  logic [31:0]          cur_addr;
  logic [31:0]          cur_wdata;
  logic                 cur_err;
  logic [ADDR_BITS-1:0] cur_idx;

  // Misaligned, or any address bit above the RAM's word index is set.
  function automatic logic addr_err(input logic [31:0] a);
    addr_err = (a[1:0] != 2'b00) || ((a >> (ADDR_BITS + 2)) != 32'd0);
  endfunction

  // With no wait states the RESP entry happens on the acceptance edge, so the
  // transaction fields come straight from the request inputs; otherwise they
  // come from the values captured at acceptance.
  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_err   = addr_err(cur_addr);
  assign cur_idx   = cur_addr[ADDR_BITS+1:2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    acc_count_d = acc_count_q;
    enter_resp  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          acc_count_d = acc_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Response payload is only loaded on RESP entry, so it holds while valid.
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_err || cur_we) ? 32'd0 : mem[cur_idx];
    end

    mem_we = enter_resp && cur_we && !cur_err && !reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      acc_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      acc_count_q <= acc_count_d;
    end
  end

  // Transaction capture registers carry data only.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // RAM has no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign acc_count = acc_count_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
module tb_mem_wait_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned due;
    int          stall;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  // instance 1: WAIT_CYCLES = 2
  logic        req_valid, req_we, req_ready, rsp_valid, rsp_err;
  logic        rsp_ready = 1'b1;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [15:0] acc_count;
  // instance 2: WAIT_CYCLES = 0
  logic        req_valid2, req_we2, req_ready2, rsp_valid2, rsp_err2;
  logic        rsp_ready2;
  logic [31:0] req_addr2, req_wdata2, rsp_rdata2;
  logic [15:0] acc_count2;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  logic [31:0] mem_model [2][64];
  exp_t        q1[$];
  exp_t        q2[$];

  exp_t        cur1;
  bit          have_cur1 = 0;
  int          hold1     = 0;
  bit          done1     = 0;
  int unsigned last_cmpl1 = 0;
  logic [15:0] exp_acc   = 16'd0;

  logic [15:0] exp_acc2  = 16'd0;
  bit          acc_pend2 = 0;

  mem_wait_responder #(.ADDR_BITS(6), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .acc_count(acc_count)
  );

  mem_wait_responder #(.ADDR_BITS(6), .WAIT_CYCLES(0)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .acc_count(acc_count2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: error on misalignment or any byte address >= 4*64,
  // reads return the last value written, writes and errors return 0.
  function automatic exp_t model_op(input int d, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata);
    exp_t e;
    e.err   = (addr % 4 != 0) || (addr >= 32'd256);
    e.rdata = (e.err || we) ? 32'd0 : mem_model[d][addr[7:2]];
    if (we && !e.err) mem_model[d][addr[7:2]] = wdata;
    e.due   = 0;
    e.stall = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_addr(input int words);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = (32'($urandom_range(0, words - 1)) << 2) | 32'($urandom_range(1, 3));
      1:       a = ($urandom | 32'h100) & 32'hFFFF_FFFC;
      default: a = 32'($urandom_range(0, words - 1)) << 2;
    endcase
    return a;
  endfunction

  // ---------------- instance 1 monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_acc_count", 32'(acc_count), 32'd0);
      exp_acc   = 16'd0;
      have_cur1 = 0;
      done1     = 0;
      rsp_ready = 1'b1;
    end else begin
      check("acc_count", 32'(acc_count), 32'(exp_acc));
      if (done1) check("req_ready_after_cmpl", 32'(req_ready), 32'd1);
      done1 = 0;
      if (rsp_valid) begin
        check("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (!have_cur1) begin
          if (q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            cur1.err = rsp_err; cur1.rdata = rsp_rdata; cur1.stall = 0;
          end else begin
            cur1 = q1.pop_front();
            check("rsp_err", 32'(rsp_err), 32'(cur1.err));
            check("rsp_rdata", rsp_rdata, cur1.rdata);
            check("rsp_latency", cyc, cur1.due);
          end
          have_cur1 = 1;
          hold1     = cur1.stall;
        end else begin
          check("hold_err", 32'(rsp_err), 32'(cur1.err));
          check("hold_rdata", rsp_rdata, cur1.rdata);
        end
        if (hold1 > 0) begin
          rsp_ready = 1'b0;
          hold1--;
        end else begin
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (rsp_ready) begin
          exp_acc++;
          have_cur1  = 0;
          done1      = 1;
          last_cmpl1 = cyc + 1;
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- instance 2 monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_acc2  = 16'd0;
      acc_pend2 = 0;
    end else begin
      if (acc_pend2) begin
        check("acc_count2", 32'(acc_count2), 32'(exp_acc2));
        acc_pend2 = 0;
      end
      if (rsp_valid2) begin
        if (q2.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp2: got rsp_valid2=1 expected no response");
        end else begin
          exp_t e;
          e = q2.pop_front();
          check("rsp_err2", 32'(rsp_err2), 32'(e.err));
          check("rsp_rdata2", rsp_rdata2, e.rdata);
          check("rsp_latency2", cyc, e.due);
        end
        exp_acc2++;
        acc_pend2 = 1;
      end
    end
  end

  task automatic issue1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, input bit abort);
    exp_t e;
    int   guard;
    int unsigned acc_edge;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles expected 1", guard);
      req_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    if (guard > 0 && !abort) check("held_accept_cycle", acc_edge, last_cmpl1 + 1);
    if (!abort) begin
      e       = model_op(0, we, addr, wdata);
      e.due   = acc_edge + 2;
      e.stall = stall;
      q1.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble the request lines: the accepted transaction must not see these.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (abort) begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
    end
  endtask

  task automatic drain1();
    int g;
    g = 0;
    while ((q1.size() != 0 || have_cur1) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (q1.size() != 0 || have_cur1) begin
      checks++;
      failures++;
      $display("FAIL drain1_timeout: got %0d pending expected 0", q1.size());
    end
  endtask

  // Holds req_valid2 high across the whole list so requests go back-to-back.
  task automatic run2(input op_t ops[$]);
    int guard;
    int unsigned a_prev, a_now;
    exp_t e;
    a_prev = 0;
    @(negedge clk);
    for (int i = 0; i < ops.size(); i++) begin
      req_valid2 = 1'b1; req_we2 = ops[i].we; req_addr2 = ops[i].addr; req_wdata2 = ops[i].wdata;
      guard = 0;
      while (!req_ready2 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!req_ready2) begin
        checks++;
        failures++;
        $display("FAIL accept2_timeout: got req_ready2=0 expected 1");
        break;
      end
      a_now = cyc + 1;
      if (i > 0) check("b2b_spacing2", a_now - a_prev, 32'd2);
      a_prev = a_now;
      e      = model_op(1, ops[i].we, ops[i].addr, ops[i].wdata);
      e.due  = a_now;
      q2.push_back(e);
      @(posedge clk);
      #1;
      req_we2 = 1'($urandom); req_addr2 = $urandom; req_wdata2 = $urandom;
      @(negedge clk);
    end
    req_valid2 = 1'b0;
  endtask

  task automatic drain2();
    int g;
    g = 0;
    while ((q2.size() != 0 || acc_pend2) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (q2.size() != 0 || acc_pend2) begin
      checks++;
      failures++;
      $display("FAIL drain2_timeout: got %0d pending expected 0", q2.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t ops[$];
    op_t o;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 32'd0; req_wdata2 = 32'd0;
    rsp_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Fill every RAM word so later reads have known contents.
    for (int w = 0; w < 64; w++) issue1(1'b1, 32'(w) << 2, $urandom, 0, 1'b0);

    issue1(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    issue1(1'b0, 32'h10, 32'h0, 0, 1'b0);
    issue1(1'b0, 32'h12, 32'h0, 0, 1'b0);
    issue1(1'b0, 32'h100, 32'h0, 0, 1'b0);
    issue1(1'b1, 32'h100, 32'h5A5A5A5A, 0, 1'b0);
    issue1(1'b0, 32'h0, 32'h0, 0, 1'b0);
    issue1(1'b1, 32'h13, 32'hCAFEF00D, 0, 1'b0);
    issue1(1'b0, 32'h10, 32'h0, 5, 1'b0);
    issue1(1'b1, 32'h14, 32'h12345678, 0, 1'b0);
    issue1(1'b0, 32'h14, 32'h0, 0, 1'b0);

    // Reset during WAIT of a write: old value must survive.
    issue1(1'b1, 32'h20, 32'h1111, 0, 1'b0);
    drain1();
    issue1(1'b1, 32'h20, 32'h2222, 0, 1'b1);
    issue1(1'b0, 32'h20, 32'h0, 0, 1'b0);

    repeat (150) issue1(1'($urandom), rand_addr(64), $urandom, int'($urandom_range(0, 2)), 1'b0);
    drain1();

    // Zero-wait instance: back-to-back throughput and function.
    for (int w = 0; w < 8; w++) begin
      o.we = 1'b1; o.addr = 32'(w) << 2; o.wdata = $urandom;
      ops.push_back(o);
    end
    for (int k = 0; k < 16; k++) begin
      o.we = 1'($urandom); o.addr = rand_addr(8); o.wdata = $urandom;
      ops.push_back(o);
    end
    run2(ops);
    drain2();

    // Preload the response counter just below wrap, then complete one more.
    @(negedge clk);
    force dut2.acc_count_q = 16'hFFFF;
    #1 release dut2.acc_count_q;
    exp_acc2 = 16'hFFFF;
    check("acc_preload2", 32'(acc_count2), 32'h0000FFFF);
    ops.delete();
    o.we = 1'b0; o.addr = 32'h4; o.wdata = 32'h0;
    ops.push_back(o);
    run2(ops);
    drain2();
    check("acc_wrap2", 32'(acc_count2), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
